// File: rtl/wisc_alu.sv
// wisc_alu: WISC-15 execute-stage ALU. Result is purely combinational; the
// z/n/v condition flags are registered for later conditional branches.
// Build option: define ALU_SAT_EN to saturate ADD/SUB results on signed
// overflow instead of wrapping modulo 2^16.

// One barrel-shifter stage: optionally shifts by SH positions.
// The fill bit is used for right shifts only; left shifts always zero fill.
module wisc_alu_shift_stage #(
  parameter int SH = 1
) (
  input  logic [15:0] din,
  input  logic        en,
  input  logic        left,
  input  logic        fill,
  output logic [15:0] dout
);

  // Shift by SH when this stage's amount bit is set, else pass through
  always_comb begin
    dout = din;
    if (en) begin
      if (left) dout = {din[15-SH:0], {SH{1'b0}}};
      else      dout = {{SH{fill}}, din[15:SH]};
    end
  end

endmodule

module wisc_alu (
  output logic [15:0] Result,
  output logic        v,
  output logic        n,
  output logic        z,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [3:0]  Alu_Ctrl,
  input  logic        clk,
  input  logic        rst_n
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_NAND = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1100;
  localparam logic [3:0] OP_SRL  = 4'b1110;
  localparam logic [3:0] OP_SRA  = 4'b1111;

  typedef struct packed {
    logic valid;  // recognised opcode: z is updated
    logic arith;  // ADD/SUB: n and v are updated too
    logic sub;
    logic shift;
    logic left;
    logic arith_sh;
  } dec_t;

  dec_t        dec;
  logic [15:0] b_op;
  logic [15:0] sum;
  logic        ovf;
  logic [15:0] arith_res;
  logic [15:0] shift_res;
  logic [4:0][15:0] sh_pipe;

  // Decode the control code into orthogonal select bits
  always_comb begin
    dec = '0;
    unique case (Alu_Ctrl)
      OP_ADD:  begin dec.valid = 1'b1; dec.arith = 1'b1; end
      OP_SUB:  begin dec.valid = 1'b1; dec.arith = 1'b1; dec.sub = 1'b1; end
      OP_NAND: dec.valid = 1'b1;
      OP_XOR:  dec.valid = 1'b1;
      OP_SLL:  begin dec.valid = 1'b1; dec.shift = 1'b1; dec.left = 1'b1; end
      OP_SRL:  begin dec.valid = 1'b1; dec.shift = 1'b1; end
      OP_SRA:  begin dec.valid = 1'b1; dec.shift = 1'b1; dec.arith_sh = 1'b1; end
      default: dec = '0;
    endcase
  end

  // Shared adder: SUB is A + ~B + 1, so overflow reduces to the ADD rule on b_op
  always_comb begin
    b_op = dec.sub ? ~B : B;
    sum  = A + b_op + {15'd0, dec.sub};
    ovf  = (A[15] == b_op[15]) && (sum[15] != A[15]);
`ifdef ALU_SAT_EN
    // Positive operand overflowed upward, negative one overflowed downward
    if (ovf) arith_res = A[15] ? 16'h8000 : 16'h7FFF;
    else     arith_res = sum;
`else
    arith_res = sum;
`endif
  end

  // 1/2/4/8 barrel shifter driven by B[3:0]
  assign sh_pipe[0] = A;
  for (genvar g = 0; g < 4; g++) begin : g_sh
    wisc_alu_shift_stage #(.SH(1 << g)) u_stage (
      .din  (sh_pipe[g]),
      .en   (B[g]),
      .left (dec.left),
      .fill (dec.arith_sh & A[15]),
      .dout (sh_pipe[g+1])
    );
  end
  assign shift_res = sh_pipe[4];

  // Result mux; unrecognised codes produce zero
  always_comb begin
    Result = 16'h0000;
    if (dec.arith)                 Result = arith_res;
    else if (dec.shift)            Result = shift_res;
    else if (Alu_Ctrl == OP_NAND)  Result = ~(A & B);
    else if (Alu_Ctrl == OP_XOR)   Result = A ^ B;
  end

  // Condition flags: z on every valid op, n/v only on ADD/SUB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z <= 1'b0;
      n <= 1'b0;
      v <= 1'b0;
    end else if (dec.valid) begin
      z <= (Result == 16'h0000);
      if (dec.arith) begin
        n <= Result[15];
        v <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_wisc_alu.sv
module tb_wisc_alu;

  logic [15:0] Result;
  logic        v, n, z;
  logic [15:0] A, B;
  logic [3:0]  Alu_Ctrl;
  logic        clk, rst_n;

  int total = 0;
  int bad   = 0;

  wisc_alu dut (
    .Result   (Result),
    .v        (v),
    .n        (n),
    .z        (z),
    .A        (A),
    .B        (B),
    .Alu_Ctrl (Alu_Ctrl),
    .clk      (clk),
    .rst_n    (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply operands on the falling edge, let combinational logic settle
  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [3:0] c);
    @(negedge clk);
    A = a; B = b; Alu_Ctrl = c;
    #1;
  endtask

  // Advance past the next rising edge so flags can be sampled
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; A = 16'h0003; B = 16'h0004; Alu_Ctrl = 4'b0000;
    #2;
    total++;
    if ({z, n, v} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b want=000", {z, n, v});
    end
    total++;
    if (Result !== 16'h0007) begin
      bad++; $display("FAIL reset_result got=%h want=0007", Result);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    logic [15:0] a, b, exp;
    for (int i = 0; i < 64; i++) begin
      a = 16'((i * 31 * 17) & 16'h7FFF);
      b = 16'((i * 73 * 13) & 16'h7FFF);
      exp = a + b;
`ifdef ALU_SAT_EN
      if (exp[15]) exp = 16'h7FFF;
`endif
      drive(a, b, 4'b0000);
      total++;
      if (Result !== exp) begin
        bad++; $display("FAIL add_sweep a=%h b=%h got=%h want=%h", a, b, Result, exp);
      end
    end
    drive(16'h1234, 16'h4321, 4'b0000);
    total++;
    if (Result !== 16'h5555) begin
      bad++; $display("FAIL add_simple got=%h want=5555", Result);
    end
    drive(16'h7FFF, 16'h0001, 4'b0000);
    total++;
`ifdef ALU_SAT_EN
    if (Result !== 16'h7FFF) begin
      bad++; $display("FAIL add_ovf_result got=%h want=7fff", Result);
    end
`else
    if (Result !== 16'h8000) begin
      bad++; $display("FAIL add_ovf_result got=%h want=8000", Result);
    end
`endif
    tick();
    total++;
`ifdef ALU_SAT_EN
    if ({z, n, v} !== 3'b001) begin
      bad++; $display("FAIL add_ovf_flags got=%b want=001", {z, n, v});
    end
`else
    if ({z, n, v} !== 3'b011) begin
      bad++; $display("FAIL add_ovf_flags got=%b want=011", {z, n, v});
    end
`endif
  endtask

  task automatic test_sub();
    drive(16'h0005, 16'h0005, 4'b0001);
    total++;
    if (Result !== 16'h0000) begin
      bad++; $display("FAIL sub_eq_result got=%h want=0000", Result);
    end
    tick();
    total++;
    if ({z, n, v} !== 3'b100) begin
      bad++; $display("FAIL sub_eq_flags got=%b want=100", {z, n, v});
    end
    drive(16'h0003, 16'h0005, 4'b0001);
    total++;
    if (Result !== 16'hFFFE) begin
      bad++; $display("FAIL sub_neg_result got=%h want=fffe", Result);
    end
    drive(16'h8000, 16'h0001, 4'b0001);
    total++;
`ifdef ALU_SAT_EN
    if (Result !== 16'h8000) begin
      bad++; $display("FAIL sub_ovf_result got=%h want=8000", Result);
    end
`else
    if (Result !== 16'h7FFF) begin
      bad++; $display("FAIL sub_ovf_result got=%h want=7fff", Result);
    end
`endif
    tick();
    total++;
`ifdef ALU_SAT_EN
    if ({z, n, v} !== 3'b011) begin
      bad++; $display("FAIL sub_ovf_flags got=%b want=011", {z, n, v});
    end
`else
    if ({z, n, v} !== 3'b001) begin
      bad++; $display("FAIL sub_ovf_flags got=%b want=001", {z, n, v});
    end
`endif
  endtask

  task automatic test_logic();
    logic [15:0] a, b;
    logic        n0, v0;
    for (int i = 0; i < 32; i++) begin
      a = 16'((i * 16'h0F3B + 16'h1357) & 16'hFFFF);
      b = 16'((i * 16'h2C65 + 16'hA0A0) & 16'hFFFF);
      drive(a, b, 4'b1000);
      total++;
      if (Result !== (a ^ b)) begin
        bad++; $display("FAIL xor_sweep a=%h b=%h got=%h want=%h", a, b, Result, a ^ b);
      end
      drive(a, b, 4'b0100);
      total++;
      if (Result !== ~(a & b)) begin
        bad++; $display("FAIL nand_sweep a=%h b=%h got=%h want=%h", a, b, Result, ~(a & b));
      end
    end
    // Load known n/v, then NAND to zero must keep them
    drive(16'h7FFF, 16'h0001, 4'b0000);
    tick();
`ifdef ALU_SAT_EN
    n0 = 1'b0; v0 = 1'b1;
`else
    n0 = 1'b1; v0 = 1'b1;
`endif
    drive(16'hFFFF, 16'hFFFF, 4'b0100);
    total++;
    if (Result !== 16'h0000) begin
      bad++; $display("FAIL nand_ones_result got=%h want=0000", Result);
    end
    tick();
    total++;
    if ({z, n, v} !== {1'b1, n0, v0}) begin
      bad++; $display("FAIL nand_ones_flags got=%b want=%b", {z, n, v}, {1'b1, n0, v0});
    end
  endtask

  task automatic test_shift();
    logic [15:0] va [12] = '{16'hF0F1, 16'hF0F1, 16'hF0F1, 16'hF0F1, 16'hF0F1, 16'hF0F1,
                             16'h0001, 16'h8000, 16'h8000, 16'hF0F1, 16'hF0F1, 16'hF0F1};
    logic [15:0] vb [12] = '{16'hFFF4, 16'hFFF4, 16'hFFF4, 16'hFFF0, 16'hFFF0, 16'hFFF0,
                             16'h000F, 16'h000F, 16'h000F, 16'h0008, 16'h0002, 16'h0009};
    logic [3:0]  vc [12] = '{4'b1100, 4'b1110, 4'b1111, 4'b1100, 4'b1110, 4'b1111,
                             4'b1100, 4'b1110, 4'b1111, 4'b1110, 4'b1100, 4'b1111};
    logic [15:0] ve [12] = '{16'h0F10, 16'h0F0F, 16'hFF0F, 16'hF0F1, 16'hF0F1, 16'hF0F1,
                             16'h8000, 16'h0001, 16'hFFFF, 16'h00F0, 16'hC3C4, 16'hFFF8};
    for (int i = 0; i < 12; i++) begin
      drive(va[i], vb[i], vc[i]);
      total++;
      if (Result !== ve[i]) begin
        bad++; $display("FAIL shift_%0d ctrl=%b a=%h b=%h got=%h want=%h",
                        i, vc[i], va[i], vb[i], Result, ve[i]);
      end
    end
    // Shift to zero sets z
    drive(16'h0001, 16'h0001, 4'b1110);
    tick();
    total++;
    if (z !== 1'b1) begin
      bad++; $display("FAIL shift_zero_z got=%b want=1", z);
    end
  endtask

  task automatic test_flags();
    logic n0;
`ifdef ALU_SAT_EN
    n0 = 1'b0;
`else
    n0 = 1'b1;
`endif
    drive(16'h7FFF, 16'h0001, 4'b0000);
    tick();
    drive(16'hFFFF, 16'hFFFF, 4'b0100);
    tick();
    total++;
    if ({z, n, v} !== {1'b1, n0, 1'b1}) begin
      bad++; $display("FAIL flags_set got=%b want=%b", {z, n, v}, {1'b1, n0, 1'b1});
    end
    // Invalid opcode: zero result, flags held across the edge
    drive(16'h1234, 16'h5678, 4'b0010);
    total++;
    if (Result !== 16'h0000) begin
      bad++; $display("FAIL invalid_result got=%h want=0000", Result);
    end
    tick();
    total++;
    if ({z, n, v} !== {1'b1, n0, 1'b1}) begin
      bad++; $display("FAIL invalid_flags got=%b want=%b", {z, n, v}, {1'b1, n0, 1'b1});
    end
    // Asynchronous reset between edges
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({z, n, v} !== 3'b000) begin
      bad++; $display("FAIL async_reset got=%b want=000", {z, n, v});
    end
    A = 16'h0000; B = 16'h0000; Alu_Ctrl = 4'b0000;
    tick();
    total++;
    if ({z, n, v} !== 3'b000) begin
      bad++; $display("FAIL reset_held got=%b want=000", {z, n, v});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if ({z, n, v} !== 3'b100) begin
      bad++; $display("FAIL post_reset got=%b want=100", {z, n, v});
    end
  endtask

  task automatic test_midcycle();
    // Flags follow only the values present at the rising edge
    drive(16'h0000, 16'h0000, 4'b0000);
    #2;
    A = 16'h8000; B = 16'h0001;
    tick();
    total++;
    if ({z, n, v} !== 3'b010) begin
      bad++; $display("FAIL midcycle_flags got=%b want=010", {z, n, v});
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_shift();
    test_flags();
    test_midcycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
